vc_fifo_bank: RTL and testbench

VC_FIFO_BANK -- requirements
Module: vc_fifo_bank

---
 rtl/vc_fifo_bank.sv | 162 ++++++++++++++++
 tb/tb_vc_fifo_bank.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: NUM_VC independent circular FIFOs sharing one push port and
// one pop port. Pop data is registered, head_data exposes the head of rd_vc
// combinationally for an external arbiter, and per-channel status is derived
// from the occupancy counters.
module vc_fifo_bank #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_VC     = 2,
   localparam int VCW       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                init,
   input  logic                                wr_enable,
   input  logic [VCW-1:0]                      wr_vc,
   input  logic [DATA_WIDTH-1:0]               data_in,
   input  logic                                rd_enable,
   input  logic [VCW-1:0]                      rd_vc,
   input  logic [ADDR_WIDTH-1:0]               umbral_full,
   input  logic [ADDR_WIDTH-1:0]               umbral_empty,
   output logic [DATA_WIDTH-1:0]               data_out,
   output logic                                valid_out,
   output logic [DATA_WIDTH-1:0]               head_data,
   output logic [NUM_VC-1:0]                   full,
   output logic [NUM_VC-1:0]                   empty,
   output logic [NUM_VC-1:0]                   almost_full,
   output logic [NUM_VC-1:0]                   almost_empty,
   output logic [NUM_VC-1:0]                   error,
   output logic [NUM_VC*(ADDR_WIDTH+1)-1:0]    count
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;
   // DEPTH expressed at counter width so every threshold compare stays at CW bits
   localparam logic [CW-1:0]  DEPTH_L  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [VCW:0]   NUM_VC_L = (VCW+1)'(NUM_VC);

   // Storage is deliberately not reset: pointers and counts define validity.
   logic [DATA_WIDTH-1:0] mem_q [NUM_VC][DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q [NUM_VC];
   logic [ADDR_WIDTH-1:0] wr_ptr_d [NUM_VC];
   logic [ADDR_WIDTH-1:0] rd_ptr_q [NUM_VC];
   logic [ADDR_WIDTH-1:0] rd_ptr_d [NUM_VC];
   logic [CW-1:0]         cnt_q    [NUM_VC];
   logic [CW-1:0]         cnt_d    [NUM_VC];
   logic [NUM_VC-1:0]     err_q, err_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_out_q, valid_out_d;

   logic                  run_s;
   logic                  wr_ok_s, rd_ok_s;
   logic [VCW-1:0]        wr_idx_s, rd_idx_s;
   logic                  push_req_s, push_acc_s;
   logic                  pop_req_s, pop_acc_s;
   logic [DATA_WIDTH-1:0] head_s;
   logic [NUM_VC-1:0]     push_vc_s, pop_vc_s, ovf_vc_s, udf_vc_s;

   // Decode requests: out-of-range channels are ignored, a pop is judged on
   // the pre-edge count (no bypass), and a push into a full channel is only
   // accepted when the same channel is popped on this edge.
   always_comb begin
      run_s      = init & ~reset;
      wr_ok_s    = ({1'b0, wr_vc} < NUM_VC_L);
      rd_ok_s    = ({1'b0, rd_vc} < NUM_VC_L);
      wr_idx_s   = wr_ok_s ? wr_vc : {VCW{1'b0}};
      rd_idx_s   = rd_ok_s ? rd_vc : {VCW{1'b0}};
      pop_req_s  = run_s & rd_enable & rd_ok_s;
      pop_acc_s  = pop_req_s & (cnt_q[rd_idx_s] != {CW{1'b0}});
      push_req_s = run_s & wr_enable & wr_ok_s;
      push_acc_s = push_req_s &
                   ((cnt_q[wr_idx_s] != DEPTH_L) | (pop_acc_s & (rd_idx_s == wr_idx_s)));
      head_s     = mem_q[rd_idx_s][rd_ptr_q[rd_idx_s]];
      push_vc_s  = {NUM_VC{1'b0}};
      pop_vc_s   = {NUM_VC{1'b0}};
      ovf_vc_s   = {NUM_VC{1'b0}};
      udf_vc_s   = {NUM_VC{1'b0}};
      for (int v = 0; v < NUM_VC; v++) begin
         push_vc_s[v] = push_acc_s & (wr_idx_s == VCW'(v));
         pop_vc_s[v]  = pop_acc_s  & (rd_idx_s == VCW'(v));
         ovf_vc_s[v]  = push_req_s & ~push_acc_s & (wr_idx_s == VCW'(v));
         udf_vc_s[v]  = pop_req_s  & ~pop_acc_s  & (rd_idx_s == VCW'(v));
      end
   end

   // Next-state for pointers, counts, sticky errors and the pop data register.
   always_comb begin
      data_out_d  = pop_acc_s ? head_s : data_out_q;
      valid_out_d = pop_acc_s;
      err_d       = err_q | ovf_vc_s | udf_vc_s;
      for (int v = 0; v < NUM_VC; v++) begin
         wr_ptr_d[v] = push_vc_s[v] ? (wr_ptr_q[v] + ADDR_WIDTH'(1)) : wr_ptr_q[v];
         rd_ptr_d[v] = pop_vc_s[v]  ? (rd_ptr_q[v] + ADDR_WIDTH'(1)) : rd_ptr_q[v];
         case ({push_vc_s[v], pop_vc_s[v]})
            2'b10:   cnt_d[v] = cnt_q[v] + CW'(1);
            2'b01:   cnt_d[v] = cnt_q[v] - CW'(1);
            default: cnt_d[v] = cnt_q[v];
         endcase
      end
   end

   // State register: reset or a deasserted run enable returns to an empty bank.
   always_ff @(posedge clk) begin
      if (reset || !init) begin
         for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_q[v] <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q[v] <= {ADDR_WIDTH{1'b0}};
            cnt_q[v]    <= {CW{1'b0}};
         end
         err_q       <= {NUM_VC{1'b0}};
         data_out_q  <= {DATA_WIDTH{1'b0}};
         valid_out_q <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_q[v] <= wr_ptr_d[v];
            rd_ptr_q[v] <= rd_ptr_d[v];
            cnt_q[v]    <= cnt_d[v];
         end
         err_q       <= err_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   // Entry storage write; acceptance already excludes reset and idle cycles.
   always_ff @(posedge clk) begin
      if (push_acc_s) begin
         mem_q[wr_idx_s][wr_ptr_q[wr_idx_s]] <= data_in;
      end
   end

   // Per-channel status from the occupancy counters, forced idle while held in reset.
   always_comb begin
      full         = {NUM_VC{1'b0}};
      empty        = {NUM_VC{1'b1}};
      almost_full  = {NUM_VC{1'b0}};
      almost_empty = {NUM_VC{1'b0}};
      count        = {(NUM_VC*CW){1'b0}};
      for (int v = 0; v < NUM_VC; v++) begin
         count[v*CW +: CW] = cnt_q[v];
         if (run_s) begin
            full[v]         = (cnt_q[v] == DEPTH_L);
            empty[v]        = (cnt_q[v] == {CW{1'b0}});
            almost_full[v]  = (cnt_q[v] >= (DEPTH_L - {1'b0, umbral_full})) &&
                              (cnt_q[v] < DEPTH_L);
            almost_empty[v] = (cnt_q[v] <= {1'b0, umbral_empty}) &&
                              (cnt_q[v] > {CW{1'b0}});
         end else begin
            full[v]         = 1'b0;
            empty[v]        = 1'b1;
            almost_full[v]  = 1'b0;
            almost_empty[v] = 1'b0;
         end
      end
   end

   assign head_data = rd_ok_s ? head_s : {DATA_WIDTH{1'b0}};
   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;
   assign error     = err_q;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Bench for vc_fifo_bank: directed scenarios followed by randomized traffic,
// compared against a queue-per-channel reference model. Popped words flow
// through a scoreboard queue checked by an independent output monitor.
module tb_vc_fifo_bank;

   localparam int DW    = 6;
   localparam int AW    = 4;
   localparam int NV    = 2;
   localparam int VCW   = 1;
   localparam int DEPTH = 16;
   localparam int CW    = AW + 1;

   logic              clk;
   logic              reset, init;
   logic              wr_enable, rd_enable;
   logic [VCW-1:0]    wr_vc, rd_vc;
   logic [DW-1:0]     data_in;
   logic [AW-1:0]     umbral_full, umbral_empty;
   logic [DW-1:0]     data_out, head_data;
   logic              valid_out;
   logic [NV-1:0]     full, empty, almost_full, almost_empty, error;
   logic [NV*CW-1:0]  count;

   vc_fifo_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VC(NV)) dut (
      .clk(clk), .reset(reset), .init(init),
      .wr_enable(wr_enable), .wr_vc(wr_vc), .data_in(data_in),
      .rd_enable(rd_enable), .rd_vc(rd_vc),
      .umbral_full(umbral_full), .umbral_empty(umbral_empty),
      .data_out(data_out), .valid_out(valid_out), .head_data(head_data),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .error(error), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one queue per channel plus sticky error bits.
   logic [DW-1:0] mq [NV][$];
   logic [NV-1:0] m_err;

   // Scoreboard: per edge, 0 = data held, 1 = word popped, 2 = cleared by reset.
   int            exp_code_q[$];
   logic [DW-1:0] exp_data_q[$];

   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Output monitor: consumes one scoreboard entry per edge.
   int            mon_code;
   logic [DW-1:0] mon_last;
   initial begin
      mon_last = '0;
      forever begin
         @(negedge clk);
         if (exp_code_q.size() > 0) begin
            mon_code = exp_code_q.pop_front();
            chk("valid_out", int'(valid_out), (mon_code == 1) ? 1 : 0);
            if (mon_code == 1) mon_last = exp_data_q.pop_front();
            else if (mon_code == 2) mon_last = '0;
            chk("data_out", int'(data_out), int'(mon_last));
         end
      end
   end

   task automatic check_status();
      int  ecnt, ef, ee, eaf, eae, sz;
      bit  hold;
      ecnt = 0; ef = 0; ee = 0; eaf = 0; eae = 0;
      hold = reset || !init;
      for (int v = 0; v < NV; v++) begin
         sz = mq[v].size();
         ecnt |= sz << (v * CW);
         if (hold) begin
            ee |= 1 << v;
         end else begin
            if (sz == DEPTH) ef |= 1 << v;
            if (sz == 0) ee |= 1 << v;
            if (sz >= DEPTH - int'(umbral_full) && sz < DEPTH) eaf |= 1 << v;
            if (sz <= int'(umbral_empty) && sz > 0) eae |= 1 << v;
         end
      end
      chk("count", int'(count), ecnt);
      chk("full", int'(full), ef);
      chk("empty", int'(empty), ee);
      chk("almost_full", int'(almost_full), eaf);
      chk("almost_empty", int'(almost_empty), eae);
      chk("error", int'(error), int'(m_err));
   endtask

   // One clock of stimulus: drive, check head, apply the model at the edge, check status.
   task automatic step(input bit rs, input bit in, input bit we, input int wv,
                       input int din, input bit re, input int rv);
      bit pop_ok, push_ok;
      logic [DW-1:0] d;
      logic [DW-1:0] dv;
      dv = din[DW-1:0];
      reset = rs; init = in;
      wr_enable = we; wr_vc = wv[VCW-1:0]; data_in = dv;
      rd_enable = re; rd_vc = rv[VCW-1:0];
      #1;
      if (rv < NV && mq[rv].size() > 0) chk("head_data", int'(head_data), int'(mq[rv][0]));
      @(posedge clk);
      if (rs || !in) begin
         for (int v = 0; v < NV; v++) mq[v].delete();
         m_err = '0;
         exp_code_q.push_back(2);
      end else begin
         pop_ok  = re && rv < NV && mq[rv].size() > 0;
         push_ok = we && wv < NV && (mq[wv].size() < DEPTH || (pop_ok && rv == wv));
         if (re && rv < NV && !pop_ok) m_err[rv] = 1'b1;
         if (we && wv < NV && !push_ok) m_err[wv] = 1'b1;
         if (pop_ok) begin
            d = mq[rv].pop_front();
            exp_data_q.push_back(d);
         end
         if (push_ok) mq[wv].push_back(dv);
         exp_code_q.push_back(pop_ok ? 1 : 0);
      end
      #1;
      check_status();
      @(negedge clk);
   endtask

   initial begin
      m_err = '0;
      reset = 1'b1; init = 1'b1;
      wr_enable = 1'b0; rd_enable = 1'b0;
      wr_vc = '0; rd_vc = '0; data_in = '0;
      umbral_full = 4'd3; umbral_empty = 4'd2;
      @(negedge clk);

      // Reset state
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);

      // Fill VC0 with 0..15: almost_full from 13, full at 16
      for (int i = 0; i < 16; i++) step(0, 1, 1, 0, i, 0, 0);
      // Overflow: dropped word, sticky error on VC0
      step(0, 1, 1, 0, 'h3F, 0, 0);
      // Pop 8, push 8 across the wrap point, then drain completely
      for (int i = 0; i < 8; i++)  step(0, 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++)  step(0, 1, 1, 0, 16 + i, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 1, 0);
      // Underflow on empty VC0
      step(0, 1, 0, 0, 0, 1, 0);

      // Pop empty VC1 with same-edge push of 0x2A, then pop it
      step(0, 1, 1, 1, 'h2A, 1, 1);
      step(0, 1, 0, 0, 0, 1, 1);

      // Full VC1 with simultaneous push and pop
      for (int i = 0; i < 16; i++) step(0, 1, 1, 1, 'h20 + i, 0, 0);
      step(0, 1, 1, 1, 'h3A, 1, 1);

      // Interleaved push to VC0 / pop from VC1
      for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 'h10 + i, 1, 1);

      // Reset with VC0 at count 7, then pushes while init is low
      step(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 'h30 + i, 0, 0);
      step(1, 1, 1, 0, 'h11, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, i % 2, 'h15 + i, 0, 0);
      step(0, 1, 0, 0, 0, 1, 0);

      // Randomized traffic with alternating fill and drain bias
      for (int i = 0; i < 1200; i++) begin
         int wp;
         bit rs, in;
         wp = ((i / 100) % 2 == 0) ? 70 : 30;
         rs = ($urandom_range(0, 199) == 0);
         in = ($urandom_range(0, 149) != 0);
         umbral_full  = AW'($urandom_range(0, DEPTH - 1));
         umbral_empty = AW'($urandom_range(0, DEPTH - 1));
         step(rs, in,
              ($urandom_range(0, 99) < wp), $urandom_range(0, NV - 1),
              $urandom_range(0, (1 << DW) - 1),
              ($urandom_range(0, 99) < (100 - wp)), $urandom_range(0, NV - 1));
      end

      #3;
      chk("scoreboard_drain", exp_code_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
